// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller and its datapath.
// The controller takes the master modport: it reads the instruction fields,
// comparator flags and memory handshake, and drives every control output.
interface multicycle_ctrl_if;
    // instruction fields, comparator result and memory handshake
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic [2:0] GES;
    logic       mem_ready;

    // control outputs
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALU_Control;
    logic [2:0] ImmSrc;
    logic [1:0] ResultSrc;
    logic [1:0] Ext_Data_Val;
    logic       Ext_Data_Src;
    logic [1:0] Ext_rs2_Src;
    logic [3:0] state;
    logic       illegal;

    modport master (
        input  op, funct3, funct7_5, GES, mem_ready,
        output MemRead, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc,
               ALUSrcA, ALUSrcB, ALU_Control, ImmSrc, ResultSrc,
               Ext_Data_Val, Ext_Data_Src, Ext_rs2_Src, state, illegal
    );

    modport slave (
        output op, funct3, funct7_5, GES, mem_ready,
        input  MemRead, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc,
               ALUSrcA, ALUSrcB, ALU_Control, ImmSrc, ResultSrc,
               Ext_Data_Val, Ext_Data_Src, Ext_rs2_Src, state, illegal
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I main controller.
// Two-process FSM: a registered state and a combinational block that
// produces both the next state and every datapath control from the current
// state and instruction fields. Strobes are gated by rst so that an
// asserted reset kills any memory or register write in the same cycle.
// An unknown opcode parks the FSM in TRAP until reset.
module multicycle_ctrl (
    input  logic                clk,
    input  logic                rst,
    multicycle_ctrl_if.master   bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_JAL    = 4'd9,
        S_BRANCH = 4'd10,
        S_LUI    = 4'd11,
        S_AUIPC  = 4'd12,
        S_JALR   = 4'd13,
        S_TRAP   = 4'd15
    } state_t;

    // opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU operations
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SRL  = 4'b0010;
    localparam logic [3:0] ALU_SRA  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b1001;

    // immediate formats
    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_J     = 3'b011;
    localparam logic [2:0] IMM_U     = 3'b100;
    localparam logic [2:0] IMM_SHAMT = 3'b101;

    // operand and result selects
    localparam logic [1:0] SRCA_RS1   = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALU    = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_PC4    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    // ALU operation for R-type and I-type arithmetic; SUB exists only in R-type
    function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                              input logic       f7,
                                              input logic       is_r);
        logic [3:0] v;
        case (f3)
            3'b000:  v = (is_r && f7) ? ALU_SUB : ALU_ADD;
            3'b001:  v = ALU_SLL;
            3'b010:  v = ALU_SLT;
            3'b011:  v = ALU_SLTU;
            3'b100:  v = ALU_XOR;
            3'b101:  v = f7 ? ALU_SRA : ALU_SRL;
            3'b110:  v = ALU_OR;
            3'b111:  v = ALU_AND;
            default: v = ALU_ADD;
        endcase
        return v;
    endfunction

    // branch decision from the one-hot comparator flags {GE, EQ, LT}
    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic [2:0] ges);
        logic t;
        case (f3)
            3'b000:  t = ges[1];
            3'b001:  t = ~ges[1];
            3'b100:  t = ges[0];
            3'b110:  t = ges[0];
            3'b101:  t = ges[1] | ges[2];
            3'b111:  t = ges[1] | ges[2];
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // immediate format used by DECODE to precompute the jump/branch target
    function automatic logic [2:0] decode_imm(input logic [6:0] opc);
        logic [2:0] v;
        case (opc)
            OP_STORE:  v = IMM_S;
            OP_BRANCH: v = IMM_B;
            OP_JAL:    v = IMM_J;
            OP_LUI:    v = IMM_U;
            OP_AUIPC:  v = IMM_U;
            default:   v = IMM_I;
        endcase
        return v;
    endfunction

    // dispatch target of DECODE
    function automatic state_t dispatch(input logic [6:0] opc);
        state_t s;
        case (opc)
            OP_LOAD:   s = S_MEMADR;
            OP_STORE:  s = S_MEMADR;
            OP_R:      s = S_EXEC_R;
            OP_I:      s = S_EXEC_I;
            OP_JAL:    s = S_JAL;
            OP_JALR:   s = S_JALR;
            OP_BRANCH: s = S_BRANCH;
            OP_LUI:    s = S_LUI;
            OP_AUIPC:  s = S_AUIPC;
            default:   s = S_TRAP;
        endcase
        return s;
    endfunction

    state_t     r_state;
    state_t     w_next_state;
    logic       r_illegal;

    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_reg_write;
    logic       w_adr_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [3:0] w_alu_control;
    logic [2:0] w_imm_src;
    logic [1:0] w_result_src;
    logic [1:0] w_ext_data_val;
    logic       w_ext_data_src;
    logic [1:0] w_ext_rs2_src;

    // state register; reset returns to FETCH immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // sticky illegal flag, set on entry to TRAP and cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (w_next_state == S_TRAP) begin
            r_illegal <= 1'b1;
        end else begin
            r_illegal <= r_illegal;
        end
    end

    // next-state and control decode for the current state
    always_comb begin
        w_next_state   = r_state;
        w_mem_read     = 1'b0;
        w_mem_write    = 1'b0;
        w_ir_write     = 1'b0;
        w_pc_write     = 1'b0;
        w_reg_write    = 1'b0;
        w_adr_src      = 1'b0;
        w_alu_src_a    = SRCA_RS1;
        w_alu_src_b    = SRCB_RS2;
        w_alu_control  = ALU_ADD;
        w_imm_src      = IMM_I;
        w_result_src   = RES_ALU;
        w_ext_data_val = 2'b00;
        w_ext_data_src = 1'b0;
        w_ext_rs2_src  = 2'b00;

        case (r_state)
            S_FETCH: begin
                // PC+4 is computed while the instruction is read
                w_mem_read  = 1'b1;
                w_adr_src   = 1'b0;
                w_alu_src_a = SRCA_PC;
                w_alu_src_b = SRCB_FOUR;
                if (bus.mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_next_state = S_DECODE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                w_alu_src_a  = SRCA_OLDPC;
                w_alu_src_b  = SRCB_IMM;
                w_imm_src    = decode_imm(bus.op);
                w_next_state = dispatch(bus.op);
            end
            S_MEMADR: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_src_b = SRCB_IMM;
                if (bus.op == OP_LOAD) begin
                    w_imm_src    = IMM_I;
                    w_next_state = S_MEMRD;
                end else begin
                    w_imm_src    = IMM_S;
                    w_next_state = S_MEMWR;
                end
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                w_adr_src  = 1'b1;
                if (bus.mem_ready) begin
                    w_next_state = S_MEMWB;
                end else begin
                    w_next_state = S_MEMRD;
                end
            end
            S_MEMWB: begin
                // {size, sign/zero extend} applied to the loaded word
                w_reg_write  = 1'b1;
                w_result_src = RES_MEM;
                case (bus.funct3)
                    3'b000:  {w_ext_data_val, w_ext_data_src} = {2'b11, 1'b1};
                    3'b001:  {w_ext_data_val, w_ext_data_src} = {2'b10, 1'b1};
                    3'b010:  {w_ext_data_val, w_ext_data_src} = {2'b00, 1'b0};
                    3'b100:  {w_ext_data_val, w_ext_data_src} = {2'b01, 1'b1};
                    3'b101:  {w_ext_data_val, w_ext_data_src} = {2'b00, 1'b1};
                    default: {w_ext_data_val, w_ext_data_src} = {2'b00, 1'b0};
                endcase
                w_next_state = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                w_adr_src   = 1'b1;
                w_imm_src   = IMM_S;
                case (bus.funct3)
                    3'b000:  w_ext_rs2_src = 2'b10;
                    3'b001:  w_ext_rs2_src = 2'b01;
                    default: w_ext_rs2_src = 2'b00;
                endcase
                if (bus.mem_ready) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_MEMWR;
                end
            end
            S_EXEC_R: begin
                w_alu_src_a   = SRCA_RS1;
                w_alu_src_b   = SRCB_RS2;
                w_alu_control = alu_decode(bus.funct3, bus.funct7_5, 1'b1);
                w_next_state  = S_ALUWB;
            end
            S_EXEC_I: begin
                w_alu_src_a   = SRCA_RS1;
                w_alu_src_b   = SRCB_IMM;
                w_alu_control = alu_decode(bus.funct3, bus.funct7_5, 1'b0);
                if ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b101)) begin
                    w_imm_src = IMM_SHAMT;
                end else begin
                    w_imm_src = IMM_I;
                end
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
                w_result_src = RES_ALU;
                w_next_state = S_FETCH;
            end
            S_JAL: begin
                // target old PC + J imm was latched in DECODE
                w_pc_write   = 1'b1;
                w_reg_write  = 1'b1;
                w_result_src = RES_PC4;
                w_alu_src_a  = SRCA_OLDPC;
                w_alu_src_b  = SRCB_IMM;
                w_imm_src    = IMM_J;
                w_next_state = S_FETCH;
            end
            S_JALR: begin
                // rs1 + I imm; the datapath clears bit 0 of the target
                w_pc_write   = 1'b1;
                w_reg_write  = 1'b1;
                w_result_src = RES_PC4;
                w_alu_src_a  = SRCA_RS1;
                w_alu_src_b  = SRCB_IMM;
                w_imm_src    = IMM_I;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_src_b = SRCB_RS2;
                w_imm_src   = IMM_B;
                if (bus.funct3[2:1] == 2'b11) begin
                    w_alu_control = ALU_SLTU;
                end else begin
                    w_alu_control = ALU_SLT;
                end
                w_pc_write   = branch_taken(bus.funct3, bus.GES);
                w_next_state = S_FETCH;
            end
            S_LUI: begin
                w_reg_write  = 1'b1;
                w_result_src = RES_IMM;
                w_imm_src    = IMM_U;
                w_next_state = S_FETCH;
            end
            S_AUIPC: begin
                w_alu_src_a  = SRCA_OLDPC;
                w_alu_src_b  = SRCB_IMM;
                w_imm_src    = IMM_U;
                w_next_state = S_ALUWB;
            end
            S_TRAP: begin
                w_next_state = S_TRAP;
            end
            default: begin
                // unreachable encoding: treat as a fault and park
                w_next_state = S_TRAP;
            end
        endcase
    end

    // strobes are killed combinationally while reset is asserted
    assign bus.MemRead      = w_mem_read  & ~rst;
    assign bus.MemWrite     = w_mem_write & ~rst;
    assign bus.IRWrite      = w_ir_write  & ~rst;
    assign bus.PCWrite      = w_pc_write  & ~rst;
    assign bus.RegWrite     = w_reg_write & ~rst;
    assign bus.AdrSrc       = w_adr_src;
    assign bus.ALUSrcA      = w_alu_src_a;
    assign bus.ALUSrcB      = w_alu_src_b;
    assign bus.ALU_Control  = w_alu_control;
    assign bus.ImmSrc       = w_imm_src;
    assign bus.ResultSrc    = w_result_src;
    assign bus.Ext_Data_Val = w_ext_data_val;
    assign bus.Ext_Data_Src = w_ext_data_src;
    assign bus.Ext_rs2_Src  = w_ext_rs2_src;
    assign bus.state        = r_state;
    assign bus.illegal      = r_illegal & ~rst;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus a
// randomized instruction stream checked against a per-class state-path model.
module tb_multicycle_ctrl;

    localparam logic [3:0] F   = 4'd0;
    localparam logic [3:0] D   = 4'd1;
    localparam logic [3:0] MA  = 4'd2;
    localparam logic [3:0] MRD = 4'd3;
    localparam logic [3:0] MWB = 4'd4;
    localparam logic [3:0] MWR = 4'd5;
    localparam logic [3:0] ER  = 4'd6;
    localparam logic [3:0] EI  = 4'd7;
    localparam logic [3:0] AW  = 4'd8;
    localparam logic [3:0] JL  = 4'd9;
    localparam logic [3:0] BR  = 4'd10;
    localparam logic [3:0] LU  = 4'd11;
    localparam logic [3:0] AU  = 4'd12;
    localparam logic [3:0] JR  = 4'd13;
    localparam logic [3:0] TP  = 4'd15;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {MemRead, MemWrite, IRWrite, PCWrite, RegWrite}
    function automatic logic [4:0] strb();
        return {bus.MemRead, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic [2:0] ges);
        bus.op = op;
        bus.funct3 = f3;
        bus.funct7_5 = f7;
        bus.GES = ges;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_instr(7'b0110011, 3'd0, 1'b0, 3'b010);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus.state !== F) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
        checks++; if (strb() !== 5'b00000) begin failures++; $display("FAIL reset_strobes got=%b exp=00000", strb()); end
        checks++; if (bus.illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", bus.illegal); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (strb() !== 5'b10110) begin failures++; $display("FAIL reset_release_fetch got=%b exp=10110", strb()); end
        step();
        #1;
        checks++; if (bus.state !== D) begin failures++; $display("FAIL reset_resume got=%0d exp=1", bus.state); end
    endtask

    task automatic test_add();
        logic [3:0] exp_s [5];
        exp_s = '{F, D, ER, AW, F};
        apply_reset();
        set_instr(7'b0110011, 3'b000, 1'b0, 3'b010);
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (bus.state !== exp_s[i]) begin failures++; $display("FAIL add_state[%0d] got=%0d exp=%0d", i, bus.state, exp_s[i]); end
            checks++; if (bus.RegWrite !== (exp_s[i] == AW)) begin failures++; $display("FAIL add_regwrite[%0d] got=%b", i, bus.RegWrite); end
            if (exp_s[i] == ER) begin
                checks++; if (bus.ALU_Control !== 4'b0000) begin failures++; $display("FAIL add_aluctl got=%b exp=0000", bus.ALU_Control); end
            end
            step();
        end
    endtask

    task automatic test_lh_stall();
        apply_reset();
        set_instr(7'b0000011, 3'b001, 1'b0, 3'b001);
        bus.mem_ready = 1'b1;
        step(); step(); step();
        for (int k = 0; k < 3; k++) begin
            bus.mem_ready = (k == 2);
            #1;
            checks++; if (bus.state !== MRD) begin failures++; $display("FAIL lh_stall_state[%0d] got=%0d exp=3", k, bus.state); end
            checks++; if ({bus.MemRead, bus.AdrSrc, bus.RegWrite, bus.MemWrite} !== 4'b1100) begin
                failures++; $display("FAIL lh_stall_ctl[%0d] got=%b exp=1100", k, {bus.MemRead, bus.AdrSrc, bus.RegWrite, bus.MemWrite});
            end
            step();
        end
        bus.mem_ready = 1'b0;
        #1;
        checks++; if (bus.state !== MWB) begin failures++; $display("FAIL lh_memwb_state got=%0d exp=4", bus.state); end
        checks++; if ({bus.Ext_Data_Val, bus.Ext_Data_Src, bus.ResultSrc, bus.RegWrite} !== 6'b101011) begin
            failures++; $display("FAIL lh_memwb_ctl got=%b exp=101011", {bus.Ext_Data_Val, bus.Ext_Data_Src, bus.ResultSrc, bus.RegWrite});
        end
        step();
        #1;
        checks++; if (bus.state !== F) begin failures++; $display("FAIL lh_return got=%0d exp=0", bus.state); end
    endtask

    task automatic test_branch();
        logic [2:0] ges_v [3];
        logic [2:0] f3_v  [2];
        logic       exp_t [2][3];
        ges_v = '{3'b001, 3'b010, 3'b100};
        f3_v  = '{3'b101, 3'b001};
        exp_t = '{'{1'b0, 1'b1, 1'b1}, '{1'b1, 1'b0, 1'b1}};
        apply_reset();
        bus.mem_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int g = 0; g < 3; g++) begin
                set_instr(7'b1100011, f3_v[b], 1'b0, ges_v[g]);
                step(); step();
                #1;
                checks++; if (bus.state !== BR) begin failures++; $display("FAIL branch_state got=%0d exp=10", bus.state); end
                checks++; if (bus.PCWrite !== exp_t[b][g]) begin
                    failures++; $display("FAIL branch_pcwrite f3=%b ges=%b got=%b exp=%b", f3_v[b], ges_v[g], bus.PCWrite, exp_t[b][g]);
                end
                checks++; if (bus.ALU_Control !== 4'b1001) begin failures++; $display("FAIL branch_aluctl got=%b exp=1001", bus.ALU_Control); end
                step();
            end
        end
    endtask

    task automatic test_sb();
        logic [3:0] exp_s [5];
        exp_s = '{F, D, MA, MWR, F};
        apply_reset();
        set_instr(7'b0100011, 3'b000, 1'b0, 3'b010);
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (bus.state !== exp_s[i]) begin failures++; $display("FAIL sb_state[%0d] got=%0d exp=%0d", i, bus.state, exp_s[i]); end
            checks++; if (bus.RegWrite !== 1'b0) begin failures++; $display("FAIL sb_regwrite[%0d] got=%b exp=0", i, bus.RegWrite); end
            if (exp_s[i] == MWR) begin
                checks++; if ({bus.MemWrite, bus.Ext_rs2_Src, bus.AdrSrc} !== 4'b1101) begin
                    failures++; $display("FAIL sb_memwr_ctl got=%b exp=1101", {bus.MemWrite, bus.Ext_rs2_Src, bus.AdrSrc});
                end
            end
            step();
        end
    endtask

    task automatic test_trap();
        apply_reset();
        set_instr(7'b1111111, 3'b000, 1'b0, 3'b010);
        bus.mem_ready = 1'b1;
        step(); step();
        for (int i = 0; i < 10; i++) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            #1;
            checks++; if ({bus.state, bus.illegal, strb()} !== {TP, 1'b1, 5'b00000}) begin
                failures++; $display("FAIL trap_hold[%0d] got state=%0d illegal=%b strb=%b exp 15/1/00000", i, bus.state, bus.illegal, strb());
            end
            step();
        end
        rst = 1'b1;
        #1;
        checks++; if ({bus.state, bus.illegal} !== {F, 1'b0}) begin
            failures++; $display("FAIL trap_reset got state=%0d illegal=%b exp 0/0", bus.state, bus.illegal);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_midwrite();
        apply_reset();
        set_instr(7'b0100011, 3'b010, 1'b0, 3'b010);
        bus.mem_ready = 1'b1;
        step(); step(); step();
        bus.mem_ready = 1'b0;
        #1;
        checks++; if ({bus.state, bus.MemWrite} !== {MWR, 1'b1}) begin
            failures++; $display("FAIL midwrite_pre got state=%0d memwrite=%b exp 5/1", bus.state, bus.MemWrite);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({bus.state, bus.MemWrite, bus.RegWrite} !== {F, 1'b0, 1'b0}) begin
            failures++; $display("FAIL midwrite_abort got state=%0d memwrite=%b exp 0/0", bus.state, bus.MemWrite);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // random back-to-back instructions against a per-class path model
    task automatic test_random_back_to_back();
        logic [6:0] ops  [9];
        logic [2:0] ldf3 [5];
        logic [3:0] path [$];
        logic [6:0] op;
        logic [2:0] f3;
        logic [2:0] ges;
        logic       f7;
        logic       mr;
        logic       taken;
        logic [3:0] s;
        logic [3:0] exp_alu;
        logic [4:0] exp_str;
        int         cls;
        int         idx;
        int         cyc;
        ops  = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
                 7'b1100111, 7'b1100011, 7'b0110111, 7'b0010111};
        ldf3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        apply_reset();
        for (int n = 0; n < 80; n++) begin
            cls = $urandom_range(0, 8);
            op  = ops[cls];
            f3  = 3'($urandom_range(0, 7));
            if (cls == 0) f3 = ldf3[$urandom_range(0, 4)];
            if (cls == 1) f3 = 3'($urandom_range(0, 2));
            f7  = 1'($urandom_range(0, 1));
            ges = 3'(1 << $urandom_range(0, 2));
            set_instr(op, f3, f7, ges);
            path.delete();
            path.push_back(F);
            path.push_back(D);
            case (cls)
                0: begin path.push_back(MA); path.push_back(MRD); path.push_back(MWB); end
                1: begin path.push_back(MA); path.push_back(MWR); end
                2: begin path.push_back(ER); path.push_back(AW); end
                3: begin path.push_back(EI); path.push_back(AW); end
                4: path.push_back(JL);
                5: path.push_back(JR);
                6: path.push_back(BR);
                7: path.push_back(LU);
                default: begin path.push_back(AU); path.push_back(AW); end
            endcase
            case (f3)
                3'd0:    taken = ges[1];
                3'd1:    taken = !ges[1];
                3'd4, 3'd6: taken = ges[0];
                3'd5, 3'd7: taken = ges[1] || ges[2];
                default: taken = 1'b0;
            endcase
            case (f3)
                3'd0: exp_alu = (cls == 2 && f7) ? 4'b0001 : 4'b0000;
                3'd1: exp_alu = 4'b0100;
                3'd2: exp_alu = 4'b1001;
                3'd3: exp_alu = 4'b1000;
                3'd4: exp_alu = 4'b0101;
                3'd5: exp_alu = f7 ? 4'b0011 : 4'b0010;
                3'd6: exp_alu = 4'b0110;
                default: exp_alu = 4'b0111;
            endcase
            if (cls == 6) exp_alu = (f3 >= 3'd6) ? 4'b1000 : 4'b1001;
            idx = 0;
            cyc = 0;
            while (idx < path.size() && cyc < 200) begin
                s  = path[idx];
                mr = ($urandom_range(0, 3) != 0);
                bus.mem_ready = mr;
                #1;
                checks++; if (bus.state !== s) begin failures++; $display("FAIL rnd_state n=%0d op=%b got=%0d exp=%0d", n, op, bus.state, s); end
                exp_str = {(s == F || s == MRD), (s == MWR), (s == F && mr),
                           ((s == F && mr) || s == JL || s == JR || (s == BR && taken)),
                           (s == MWB || s == AW || s == JL || s == JR || s == LU)};
                checks++; if (strb() !== exp_str) begin failures++; $display("FAIL rnd_strobes n=%0d state=%0d got=%b exp=%b", n, s, strb(), exp_str); end
                if (s == ER || s == EI || s == BR) begin
                    checks++; if (bus.ALU_Control !== exp_alu) begin failures++; $display("FAIL rnd_aluctl n=%0d f3=%0d f7=%b got=%b exp=%b", n, f3, f7, bus.ALU_Control, exp_alu); end
                end
                if (s == EI) begin
                    checks++; if (bus.ImmSrc !== ((f3 == 3'd1 || f3 == 3'd5) ? 3'b101 : 3'b000)) begin failures++; $display("FAIL rnd_immsrc n=%0d got=%b", n, bus.ImmSrc); end
                end
                if (s == MWB) begin
                    checks++;
                    if ({bus.Ext_Data_Val, bus.Ext_Data_Src, bus.ResultSrc} !==
                        ((f3 == 3'd0) ? 5'b11101 : (f3 == 3'd1) ? 5'b10101 : (f3 == 3'd2) ? 5'b00001 :
                         (f3 == 3'd4) ? 5'b01101 : 5'b00101)) begin
                        failures++; $display("FAIL rnd_loadext n=%0d f3=%0d got=%b", n, f3, {bus.Ext_Data_Val, bus.Ext_Data_Src, bus.ResultSrc});
                    end
                end
                if (s == MWR) begin
                    checks++; if ({bus.Ext_rs2_Src, bus.AdrSrc} !== {((f3 == 3'd0) ? 2'b10 : (f3 == 3'd1) ? 2'b01 : 2'b00), 1'b1}) begin
                        failures++; $display("FAIL rnd_storewidth n=%0d f3=%0d got=%b", n, f3, {bus.Ext_rs2_Src, bus.AdrSrc});
                    end
                end
                if (!(s == F || s == MRD || s == MWR) || mr) idx++;
                cyc++;
                step();
            end
            checks++; if (cyc >= 200) begin failures++; $display("FAIL rnd_timeout n=%0d", n); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.mem_ready = 1'b0;
        set_instr(7'b0000000, 3'd0, 1'b0, 3'b010);
        test_reset();
        test_add();
        test_lh_stall();
        test_branch();
        test_sb();
        test_trap();
        test_reset_midwrite();
        test_random_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
